// File: rtl/seven_segments_decoder_if.sv
// Segment readback bus: two active-low digit buses in, decoded value and status out.
// The decoder sits on the slave side; the driver of the segments and consumer of results is the master.
interface seven_segments_decoder_if;
  logic [6:0] segment1;   // tens digit, active-low, bit6=g .. bit0=a
  logic [6:0] segment2;   // ones digit, same encoding
  logic       clear;      // one-cycle pulse, clears the sticky error
  logic [6:0] value;      // last valid decoded value, tens*10+ones
  logic       valid;      // one-cycle pulse when value updates
  logic       error;      // sticky illegal-pattern flag
  logic       stable;     // high while the decoded pattern is held

  modport master (
    output segment1, segment2, clear,
    input  value, valid, error, stable
  );

  modport slave (
    input  segment1, segment2, clear,
    output value, valid, error, stable
  );
endinterface

// File: rtl/seven_segments_decoder.sv
// Reads back a two-digit active-low seven-segment pair, qualifies it over a stability
// window and reports each new decoded value (0-99) once, flagging illegal digit patterns.
module seven_segments_decoder #(
  parameter int unsigned STABLE_CYCLES = 4  // legal range 2..255
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  seven_segments_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_DECODE,
    ST_HOLD
  } state_t;

  localparam logic [13:0] BLANK = 14'h3FFF;
  localparam logic [7:0]  LAST  = 8'(STABLE_CYCLES - 1);

  // Returns {legal, digit}; anything outside the ten digit glyphs is illegal.
  function automatic logic [4:0] decode_digit(input logic [6:0] seg);
    case (seg)
      7'b1000000: return {1'b1, 4'd0};
      7'b1111001: return {1'b1, 4'd1};
      7'b0100100: return {1'b1, 4'd2};
      7'b0110000: return {1'b1, 4'd3};
      7'b0011001: return {1'b1, 4'd4};
      7'b0010010: return {1'b1, 4'd5};
      7'b0000010: return {1'b1, 4'd6};
      7'b1111000: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0010000: return {1'b1, 4'd9};
      default:    return 5'b0_0000;
    endcase
  endfunction

  logic [13:0] sync1_q, sync2_q;
  logic [13:0] cand_q,  cand_d;
  logic [7:0]  cnt_q,   cnt_d;
  state_t      state_q, state_d;
  logic [6:0]  value_q, value_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic        first_q, first_d;

  logic [4:0]  tens_dec, ones_dec;
  logic [6:0]  tens7, value_new;

  assign tens_dec  = decode_digit(cand_q[13:7]);
  assign ones_dec  = decode_digit(cand_q[6:0]);
  assign tens7     = {3'b000, tens_dec[3:0]};
  // tens*10 built from shifts; both digits legal bounds the sum at 99.
  assign value_new = (tens7 << 3) + (tens7 << 1) + {3'b000, ones_dec[3:0]};

  // NOTE: every variable gets its default before the case so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    valid_d = 1'b0;
    error_d = error_q;
    first_d = first_q;

    // Clear is applied first so an error raised by DECODE below overrides it.
    if (bus.clear) error_d = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (sync2_q != cand_q) begin
          cand_d = sync2_q;
          cnt_d  = '0;
        end else if (cnt_q == LAST) begin
          state_d = ST_DECODE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_DECODE: begin
        state_d = ST_HOLD;
        if (cand_q != BLANK) begin
          if (!tens_dec[4] || !ones_dec[4]) begin
            error_d = 1'b1;
          end else begin
            first_d = 1'b0;
            if (value_new != value_q || first_q) begin
              value_d = value_new;
              valid_d = 1'b1;
            end
          end
        end
      end

      ST_HOLD: begin
        if (sync2_q != cand_q) begin
          cand_d  = sync2_q;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end

      default: state_d = ST_WAIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q <= BLANK;
      sync2_q <= BLANK;
      cand_q  <= BLANK;
      cnt_q   <= '0;
      state_q <= ST_WAIT;
      value_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      first_q <= 1'b1;
    end else begin
      sync1_q <= {bus.segment1, bus.segment2};
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      value_q <= value_d;
      valid_q <= valid_d;
      error_q <= error_d;
      first_q <= first_d;
    end
  end

  assign bus.value  = value_q;
  assign bus.valid  = valid_q;
  assign bus.error  = error_q;
  assign bus.stable = (state_q == ST_HOLD);

endmodule
